// File: rtl/skintone_stream_ctrl.sv
// Frame sequencer for the fixed-latency skintone datapath: issues pixels only against
// a guaranteed result slot and buffers returned scores in a show-ahead FIFO.
module skintone_stream_ctrl #(
    parameter int unsigned LATENCY    = 16,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned PIXEL_W    = 24,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned LEN_W      = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   frame_len,
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic [PIXEL_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [PIXEL_W-1:0] dp_pixel,
    output logic               dp_valid,
    input  logic [SCORE_W-1:0] dp_result,
    input  logic               dp_result_valid,
    output logic [SCORE_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRD_W   = CNT_W + 1;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FLUSH_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [FLUSH_W-1:0]   flush_cnt;
    logic [LEN_W-1:0]     remaining;
    logic [CNT_W-1:0]     inflight;
    logic [CNT_W-1:0]     fifo_count;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [SCORE_W-1:0]   mem [FIFO_DEPTH];
    logic [CRD_W-1:0]     credits;
    logic                 ret_seen;
    logic                 push;
    logic                 pop;
    logic                 spurious;

    // Credit check and issue path; in_ready depends only on registered state.
    always_comb begin
        credits  = CRD_W'(inflight) + CRD_W'(fifo_count);
        in_ready = (state == S_RUN) && (remaining != '0) && (credits < CRD_W'(FIFO_DEPTH));
        dp_valid = in_valid && in_ready;
        dp_pixel = in_data;
    end

    // Returns are meaningless while the datapath's own valid pipe is still flushing.
    always_comb begin
        ret_seen  = dp_result_valid && (state != S_FLUSH);
        push      = ret_seen && (inflight != '0);
        spurious  = ret_seen && (inflight == '0);
        out_valid = (fifo_count != '0);
        out_data  = mem[rd_ptr];
        pop       = out_valid && out_ready;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FLUSH: begin
                if (flush_cnt == FLUSH_W'(LATENCY - 1)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (remaining == '0) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((inflight == '0) && (fifo_count == '0)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (state == S_FLUSH) begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
        end else begin
            flush_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if ((state == S_IDLE) && start) begin
            remaining <= frame_len;
        end else if (dp_valid) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({dp_valid, push})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (spurious) begin
            err <= 1'b1;
        end
    end

    // Result FIFO: storage is not reset, only the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dp_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Credit accounting makes both of these unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credits <= CRD_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_skintone_stream_ctrl.sv
// Bench for skintone_stream_ctrl: behavioural 16-cycle datapath plus a scoreboard
// that maps every accepted pixel to the score the sink must receive, in order.
module tb_skintone_stream_ctrl;
    localparam int unsigned LATENCY    = 16;
    localparam int unsigned FIFO_DEPTH = 32;
    localparam int unsigned PIXEL_W    = 24;
    localparam int unsigned SCORE_W    = 8;
    localparam int unsigned LEN_W      = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [LEN_W-1:0]   frame_len;
    logic               busy;
    logic               done;
    logic               err;
    logic [PIXEL_W-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [PIXEL_W-1:0] dp_pixel;
    logic               dp_valid;
    logic [SCORE_W-1:0] dp_result;
    logic               dp_result_valid;
    logic [SCORE_W-1:0] out_data;
    logic               out_valid;
    logic               out_ready;

    logic               inj = 1'b0;
    logic [SCORE_W-1:0] inj_data = '0;
    logic [LATENCY-1:0] pipe_v = '0;
    logic [SCORE_W-1:0] pipe_d [LATENCY];

    int src_mode = 0;
    int snk_mode = 1;
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    logic [PIXEL_W-1:0] acc_pix[$];
    int                 acc_cyc[$];
    logic [SCORE_W-1:0] pop_dat[$];
    int                 pop_cyc[$];
    int                 done_cyc[$];
    int                 dpv_cnt = 0;
    int                 dp_bad = 0;
    int                 max_out = 0;

    always #5 clk = ~clk;

    skintone_stream_ctrl #(
        .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .PIXEL_W(PIXEL_W),
        .SCORE_W(SCORE_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .busy(busy), .done(done), .err(err),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .dp_pixel(dp_pixel), .dp_valid(dp_valid),
        .dp_result(dp_result), .dp_result_valid(dp_result_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic logic [SCORE_W-1:0] score_of(input logic [PIXEL_W-1:0] p);
        return SCORE_W'(p[23:16] + (p[15:8] ^ p[7:0]));
    endfunction

    // Datapath stand-in: fixed delay, no reset on its valid pipe.
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[LATENCY-2:0], dp_valid};
        pipe_d[0] <= score_of(dp_pixel);
        for (int i = 1; i < int'(LATENCY); i++) pipe_d[i] <= pipe_d[i-1];
    end
    assign dp_result_valid = pipe_v[LATENCY-1] | inj;
    assign dp_result       = inj ? inj_data : pipe_d[LATENCY-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Source and sink behaviour, refreshed just after each edge.
    always begin
        @(posedge clk);
        #1;
        in_valid  = (src_mode == 0) ? 1'b0 : (src_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        in_data   = PIXEL_W'($urandom);
        out_ready = (snk_mode == 0) ? 1'b0 : (snk_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        if (in_valid && in_ready) begin
            acc_pix.push_back(in_data);
            acc_cyc.push_back(cyc);
        end
        if (dp_valid) dpv_cnt++;
        if ((dp_valid !== (in_valid && in_ready)) || (dp_valid && (dp_pixel !== in_data))) dp_bad++;
        if (out_valid && out_ready) begin
            pop_dat.push_back(out_data);
            pop_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (acc_pix.size() - pop_dat.size() > max_out) max_out = acc_pix.size() - pop_dat.size();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_pix.delete(); acc_cyc.delete(); pop_dat.delete(); pop_cyc.delete();
        done_cyc.delete(); dpv_cnt = 0; dp_bad = 0; max_out = 0;
    endtask

    task automatic start_frame(input int len, output int s);
        frame_len = LEN_W'(len);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cyc.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected scores derived from the accepted pixels, compared in order.
    function automatic int score_errors();
        int n = 0;
        for (int i = 0; i < pop_dat.size(); i++) begin
            if (i >= acc_pix.size() || pop_dat[i] !== score_of(acc_pix[i])) n++;
        end
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; frame_len = '0; src_mode = 1; snk_mode = 1;
        in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
        tick();
        @(negedge clk);
        tests++;
        if ({busy, done, err, in_ready, dp_valid, out_valid} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 100000", {busy, done, err, in_ready, dp_valid, out_valid});
        end
        tick();
        rst = 1'b0;
        clear_logs();
        for (int k = 1; k <= 17; k++) begin
            tick();
            inj = (k == 3) || (k == 10);
            inj_data = SCORE_W'($urandom);
            @(negedge clk);
            if (k == 15 || k == 16) begin
                tests++;
                if (busy !== (k < 16)) begin
                    fails++;
                    $display("FAIL flush_busy_k%0d: got %b expected %b", k, busy, (k < 16));
                end
            end
        end
        inj = 1'b0;
        tick();
        @(negedge clk);
        tests++;
        if (err !== 1'b0 || out_valid !== 1'b0 || pop_dat.size() != 0) begin
            fails++;
            $display("FAIL flush_ignore: got err=%b out_valid=%b pops=%0d expected 0 0 0", err, out_valid, pop_dat.size());
        end
    endtask

    task automatic test_single_frame();
        int s; bit ok;
        src_mode = 1; snk_mode = 1;
        tick();
        clear_logs();
        start_frame(4, s);
        wait_done(200, ok);
        repeat (3) tick();
        tests++;
        if (!ok) begin fails++; $display("FAIL single_done_timeout: got no done expected done"); end
        tests++;
        if (acc_pix.size() != 4 || dpv_cnt != 4 || dp_bad != 0) begin
            fails++;
            $display("FAIL single_issue: got acc=%0d dpv=%0d bad=%0d expected 4 4 0", acc_pix.size(), dpv_cnt, dp_bad);
        end else begin
            tests++;
            if (acc_cyc[0] != s + 1 || acc_cyc[3] != acc_cyc[0] + 3) begin
                fails++;
                $display("FAIL single_accept_timing: got first=%0d last=%0d expected %0d %0d", acc_cyc[0], acc_cyc[3], s + 1, s + 4);
            end
        end
        tests++;
        if (pop_dat.size() != 4 || score_errors() != 0) begin
            fails++;
            $display("FAIL single_scores: got pops=%0d errs=%0d expected 4 0", pop_dat.size(), score_errors());
        end else begin
            tests++;
            if (pop_cyc[0] != acc_cyc[0] + 17) begin
                fails++;
                $display("FAIL single_latency: got %0d expected %0d", pop_cyc[0] - acc_cyc[0], 17);
            end
            tests++;
            if (done_cyc.size() != 1 || done_cyc[0] <= pop_cyc[3] || done_cyc[0] > pop_cyc[3] + 2) begin
                fails++;
                $display("FAIL single_done_pulse: got count=%0d expected 1 pulse just after cycle %0d", done_cyc.size(), pop_cyc[3]);
            end
        end
    endtask

    task automatic test_backpressure();
        int s; bit ok;
        src_mode = 1; snk_mode = 0;
        tick();
        clear_logs();
        start_frame(100, s);
        repeat (60) tick();
        @(negedge clk);
        tests++;
        if (acc_pix.size() != FIFO_DEPTH || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_stall: got acc=%0d in_ready=%b out_valid=%b expected 32 0 1", acc_pix.size(), in_ready, out_valid);
        end
        snk_mode = 1;
        wait_done(600, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bp_done_timeout: got no done expected done"); end
        tests++;
        if (acc_pix.size() != 100 || pop_dat.size() != 100 || score_errors() != 0 || max_out > int'(FIFO_DEPTH)) begin
            fails++;
            $display("FAIL bp_delivery: got acc=%0d pops=%0d errs=%0d peak=%0d expected 100 100 0 <=32",
                     acc_pix.size(), pop_dat.size(), score_errors(), max_out);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        int s; bit ok;
        src_mode = 1; snk_mode = 1;
        tick();
        clear_logs();
        start_frame(0, s);
        wait_done(50, ok);
        tests++;
        if (!ok || dpv_cnt != 0 || acc_pix.size() != 0) begin
            fails++;
            $display("FAIL zero_len: got done=%b dpv=%0d expected 1 0", ok, dpv_cnt);
        end
        clear_logs();
        src_mode = 2;
        start_frame(10, s);
        repeat (3) tick();
        tests++;
        if (busy !== 1'b1 || done_cyc.size() != 0) begin
            fails++;
            $display("FAIL ignored_start_state: got busy=%b done=%0d expected 1 0", busy, done_cyc.size());
        end
        start_frame(50, s);
        wait_done(300, ok);
        repeat (10) tick();
        tests++;
        if (!ok || acc_pix.size() != 10 || pop_dat.size() != 10 || score_errors() != 0 || done_cyc.size() != 1) begin
            fails++;
            $display("FAIL ignored_start: got acc=%0d pops=%0d errs=%0d dones=%0d expected 10 10 0 1",
                     acc_pix.size(), pop_dat.size(), score_errors(), done_cyc.size());
        end
    endtask

    task automatic test_spurious();
        int s; bit ok;
        src_mode = 2; snk_mode = 2;
        tick();
        clear_logs();
        inj_data = SCORE_W'($urandom);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        tests++;
        if (err !== 1'b1 || out_valid !== 1'b0 || pop_dat.size() != 0) begin
            fails++;
            $display("FAIL spurious_err: got err=%b out_valid=%b expected 1 0", err, out_valid);
        end
        tick();
        start_frame(6, s);
        wait_done(300, ok);
        tests++;
        if (!ok || pop_dat.size() != 6 || score_errors() != 0 || err !== 1'b1) begin
            fails++;
            $display("FAIL spurious_sticky: got pops=%0d errs=%0d err=%b expected 6 0 1", pop_dat.size(), score_errors(), err);
        end
    endtask

    task automatic test_back_to_back();
        int s; int len; bit ok;
        src_mode = 1; snk_mode = 1;
        tick();
        for (int f = 0; f < 4; f++) begin
            len = (f == 0) ? 40 : $urandom_range(20, 60);
            if (f == 1) begin src_mode = 2; snk_mode = 2; end
            clear_logs();
            start_frame(len, s);
            wait_done(1000, ok);
            tests++;
            if (!ok || acc_pix.size() != len || pop_dat.size() != len || score_errors() != 0
                || max_out > int'(FIFO_DEPTH) || dp_bad != 0) begin
                fails++;
                $display("FAIL b2b_frame%0d: got acc=%0d pops=%0d errs=%0d peak=%0d expected %0d %0d 0 <=32",
                         f, acc_pix.size(), pop_dat.size(), score_errors(), max_out, len, len);
            end else if (f == 0) begin
                tests++;
                if (acc_cyc[len-1] - acc_cyc[0] != len - 1) begin
                    fails++;
                    $display("FAIL b2b_throughput: got span=%0d expected %0d", acc_cyc[len-1] - acc_cyc[0], len - 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int s; bit ok;
        src_mode = 1; snk_mode = 1;
        tick();
        clear_logs();
        start_frame(20, s);
        for (int i = 0; i < 50 && acc_pix.size() < 5; i++) tick();
        #1;
        src_mode = 0; in_valid = 1'b0; rst = 1'b1;
        tests++;
        if (acc_pix.size() != 5) begin
            fails++;
            $display("FAIL mid_setup: got inflight=%0d expected 5", acc_pix.size());
        end
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_state: got err=%b busy=%b expected 0 1", err, busy);
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        repeat (4) tick();
        @(negedge clk);
        tests++;
        if (!ok || pop_dat.size() != 0 || out_valid !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL mid_discard: got idle=%b pops=%0d out_valid=%b err=%b expected 1 0 0 0", ok, pop_dat.size(), out_valid, err);
        end
        tick();
        clear_logs();
        src_mode = 1;
        start_frame(3, s);
        wait_done(200, ok);
        repeat (20) tick();
        tests++;
        if (!ok || pop_dat.size() != 3 || score_errors() != 0 || err !== 1'b0) begin
            fails++;
            $display("FAIL mid_next_frame: got pops=%0d errs=%0d err=%b expected 3 0 0", pop_dat.size(), score_errors(), err);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_zero_and_ignored_start();
        test_spurious();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected summary");
        $fatal(1, "watchdog expired");
    end

endmodule
